adsr_envelope: RTL and testbench

- Per-voice linear ADSR envelope generator in the fx chain.
- Sits directly downstream of the 1 ms tick generator. It consumes that block's single-cycle `ms_tick` pulse and advances the envelope once per millisecond.
- The note `gate` starts and ends the envelope.
- The amplitude output feeds the voice VCA multiplier.

---
 rtl/adsr_envelope_pkg.sv | 23 ++
 rtl/env_sat_step.sv | 41 ++++
 rtl/adsr_envelope.sv | 135 +++++++++++++
 tb/tb_adsr_envelope.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/adsr_envelope_pkg.sv
// Shared types for the ADSR envelope: state encoding (also read by the voice
// allocator through the `state` port) and the saturating-step mode select.
package adsr_envelope_pkg;

   localparam int unsigned AMP_W_DEF  = 8;
   localparam int unsigned FRAC_W_DEF = 8;
   localparam int unsigned ENV_ACC_W  = AMP_W_DEF + FRAC_W_DEF;
   localparam int unsigned STATE_W    = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE    = 3'd0,
      ST_ATTACK  = 3'd1,
      ST_DECAY   = 3'd2,
      ST_SUSTAIN = 3'd3,
      ST_RELEASE = 3'd4
   } env_state_e;

   typedef enum logic {
      STEP_ADD = 1'b0,
      STEP_SUB = 1'b1
   } step_mode_e;

endpackage

// File: rtl/env_sat_step.sv
// Saturating add/sub of the envelope accumulator against a bound.
// done_c flags that the bound was reached (or the step is zero); next_acc_c is then the bound.
module env_sat_step
   import adsr_envelope_pkg::*;
#(
   parameter int unsigned ACC_W = ENV_ACC_W
) (
   input  logic [ACC_W-1:0] acc,
   input  logic [ACC_W-1:0] step,
   input  logic [ACC_W-1:0] bound,
   input  step_mode_e       mode,
   output logic [ACC_W-1:0] next_acc_c,
   output logic             done_c
);

   logic [ACC_W:0] sum_ext;
   logic [ACC_W:0] lim_ext;
   logic [ACC_W:0] acc_ext;
   logic [ACC_W:0] bound_ext;
   logic           step_zero;

   // One extra bit so neither the sum nor the limit can wrap.
   assign acc_ext   = {1'b0, acc};
   assign bound_ext = {1'b0, bound};
   assign sum_ext   = acc_ext + {1'b0, step};
   assign lim_ext   = bound_ext + {1'b0, step};
   assign step_zero = (step == '0);

   always_comb begin
      done_c     = 1'b0;
      next_acc_c = acc;
      if (mode == STEP_ADD) begin
         done_c     = step_zero || (sum_ext >= bound_ext);
         next_acc_c = done_c ? bound : sum_ext[ACC_W-1:0];
      end else begin
         done_c     = step_zero || (acc_ext <= lim_ext);
         next_acc_c = done_c ? bound : (acc - step);
      end
   end

endmodule

// File: rtl/adsr_envelope.sv
// Per-voice linear ADSR envelope, advanced once per ms_tick; gate edges
// take priority over tick processing and never move the accumulator.
module adsr_envelope
   import adsr_envelope_pkg::*;
#(
   parameter int unsigned AMP_W  = AMP_W_DEF,
   parameter int unsigned FRAC_W = FRAC_W_DEF
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      ms_tick,
   input  logic                      gate,
   input  logic [AMP_W+FRAC_W-1:0]   attack_step,
   input  logic [AMP_W+FRAC_W-1:0]   decay_step,
   input  logic [AMP_W+FRAC_W-1:0]   release_step,
   input  logic [AMP_W-1:0]          sustain_level,
   output logic [AMP_W-1:0]          env,
   output logic                      active,
   output logic [STATE_W-1:0]        state
);

   localparam int unsigned ACC_W = AMP_W + FRAC_W;

   env_state_e         state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic               gate_q, gate_d;
   logic               active_q, active_d;

   logic [ACC_W-1:0]   acc_max;
   logic [ACC_W-1:0]   acc_sus;
   logic               rise;
   logic               gate_fall_evt;

   step_mode_e         sat_mode;
   logic [ACC_W-1:0]   sat_step;
   logic [ACC_W-1:0]   sat_bound;
   logic [ACC_W-1:0]   sat_next_c;
   logic               sat_done_c;

   assign acc_max = '1;
   assign acc_sus = {sustain_level, FRAC_W'(0)};
   assign gate_d  = gate;
   assign rise    = gate & ~gate_q;
   assign gate_fall_evt = ~gate && ((state_q == ST_ATTACK) || (state_q == ST_DECAY) ||
                                    (state_q == ST_SUSTAIN));

   // Single shared saturating stepper, operands selected by current phase.
   always_comb begin
      sat_mode  = STEP_SUB;
      sat_step  = release_step;
      sat_bound = '0;
      case (state_q)
         ST_ATTACK: begin
            sat_mode  = STEP_ADD;
            sat_step  = attack_step;
            sat_bound = acc_max;
         end
         ST_DECAY: begin
            sat_mode  = STEP_SUB;
            sat_step  = decay_step;
            sat_bound = acc_sus;
         end
         default: ;
      endcase
   end

   env_sat_step #(
      .ACC_W (ACC_W)
   ) u_sat (
      .acc        (acc_q),
      .step       (sat_step),
      .bound      (sat_bound),
      .mode       (sat_mode),
      .next_acc_c (sat_next_c),
      .done_c     (sat_done_c)
   );

   // Next-state and accumulator update.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      if (rise) begin
         state_d = ST_ATTACK;
      end else if (gate_fall_evt) begin
         state_d = ST_RELEASE;
      end else begin
         case (state_q)
            ST_IDLE: acc_d = '0;
            ST_ATTACK: begin
               if (ms_tick) begin
                  acc_d = sat_next_c;
                  if (sat_done_c) state_d = ST_DECAY;
               end
            end
            ST_DECAY: begin
               if (ms_tick) begin
                  acc_d = sat_next_c;
                  if (sat_done_c) state_d = ST_SUSTAIN;
               end
            end
            ST_SUSTAIN: acc_d = acc_sus;
            ST_RELEASE: begin
               if (ms_tick) begin
                  acc_d = sat_next_c;
                  if (sat_done_c) state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
               acc_d   = '0;
            end
         endcase
      end
      active_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         acc_q    <= '0;
         gate_q   <= 1'b0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         gate_q   <= gate_d;
         active_q <= active_d;
      end
   end

   assign env    = acc_q[ACC_W-1:FRAC_W];
   assign active = active_q;
   assign state  = state_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope: expectations are queued as stimulus is
// applied and popped/compared when the DUT output is sampled on the falling edge.
module tb_adsr_envelope;

   localparam int S_IDLE = 0, S_ATT = 1, S_DEC = 2, S_SUS = 3, S_REL = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        ms_tick;
   logic        gate;
   logic [15:0] attack_step, decay_step, release_step;
   logic [7:0]  sustain_level;
   logic [7:0]  env;
   logic        active;
   logic [2:0]  state;

   typedef struct {
      string tag;
      int    env;
      int    st;
      int    act;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   adsr_envelope dut (
      .clk           (clk),
      .reset         (reset),
      .ms_tick       (ms_tick),
      .gate          (gate),
      .attack_step   (attack_step),
      .decay_step    (decay_step),
      .release_step  (release_step),
      .sustain_level (sustain_level),
      .env           (env),
      .active        (active),
      .state         (state)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
   endtask

   task automatic push(input string tag, input int e_env, input int e_st, input int e_act);
      exp_t e;
      e.tag = tag; e.env = e_env; e.st = e_st; e.act = e_act;
      sb.push_back(e);
   endtask

   task automatic pop_check();
      exp_t e;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         chk({e.tag, ".env"},    {24'b0, env},    32'(e.env));
         chk({e.tag, ".state"},  {29'b0, state},  32'(e.st));
         chk({e.tag, ".active"}, {31'b0, active}, 32'(e.act));
      end
   endtask

   // One-clock tick pulse; sample point is the falling edge after its posedge.
   task automatic tick();
      ms_tick = 1'b1;
      @(negedge clk);
      ms_tick = 1'b0;
   endtask

   task automatic idle_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_acc;
      reset = 1'b0; ms_tick = 1'b0; gate = 1'b0;
      attack_step = 16'h0400; decay_step = 16'h0200; release_step = 16'h0100;
      sustain_level = 8'd128;

      // Reset state
      idle_clks(2);
      push("reset", 0, S_IDLE, 0); pop_check();
      reset = 1'b1;
      idle_clks(1);
      push("idle_after_reset", 0, S_IDLE, 0); pop_check();

      // Attack ramp
      gate = 1'b1;
      push("gate_rise", 0, S_ATT, 1);
      @(negedge clk); pop_check();
      for (int i = 1; i <= 64; i++) begin
         if (i == 1)  push("attack_t1",  4,   S_ATT, 1);
         if (i == 63) push("attack_t63", 252, S_ATT, 1);
         if (i == 64) push("attack_t64", 255, S_DEC, 1);
         tick();
         if (i == 1 || i == 63 || i == 64) pop_check();
         idle_clks(3);
      end

      // Decay to sustain
      for (int k = 1; k <= 64; k++) begin
         exp_acc = 16'hFFFF - k * 16'h0200;
         if (k == 1 || k == 10 || k == 63) push($sformatf("decay_t%0d", k), exp_acc >> 8, S_DEC, 1);
         if (k == 64) push("decay_to_sustain", 128, S_SUS, 1);
         tick();
         if (k == 1 || k == 10 || k == 63 || k == 64) pop_check();
         idle_clks(3);
      end

      // Live sustain tracking, no tick needed
      sustain_level = 8'd100;
      push("sustain_track_100", 100, S_SUS, 1);
      @(negedge clk); pop_check();
      sustain_level = 8'd128;
      push("sustain_track_128", 128, S_SUS, 1);
      @(negedge clk); pop_check();

      // Release to idle
      gate = 1'b0;
      push("gate_fall", 128, S_REL, 1);
      @(negedge clk); pop_check();
      for (int k = 1; k <= 128; k++) begin
         if (k == 1)   push("release_t1",   127, S_REL, 1);
         if (k == 127) push("release_t127", 1,   S_REL, 1);
         if (k == 128) push("release_done", 0,   S_IDLE, 0);
         tick();
         if (k == 1 || k == 127 || k == 128) pop_check();
         idle_clks(1);
      end

      // Zero steps: instantaneous attack and decay
      attack_step = '0; decay_step = '0; release_step = '0;
      gate = 1'b1;
      push("zero_rise", 0, S_ATT, 1);
      @(negedge clk); pop_check();
      push("zero_attack", 255, S_DEC, 1);
      tick(); pop_check();
      push("zero_decay", 128, S_SUS, 1);
      tick(); pop_check();

      // Retrigger during release at env 60
      attack_step = 16'h0400; release_step = 16'h0100;
      gate = 1'b0;
      @(negedge clk);
      for (int k = 1; k <= 68; k++) tick();
      push("release_at_60", 60, S_REL, 1); pop_check();
      gate = 1'b1;
      push("retrigger_hold", 60, S_ATT, 1);
      @(negedge clk); pop_check();

      // Gate rise coincident with tick leaves acc untouched
      gate = 1'b0;
      push("fall_before_collide", 60, S_REL, 1);
      @(negedge clk); pop_check();
      gate = 1'b1;
      push("rise_with_tick", 60, S_ATT, 1);
      tick(); pop_check();
      push("attack_after_collide", 64, S_ATT, 1);
      tick(); pop_check();

      // Asynchronous reset mid-attack, between clock edges
      #2 reset = 1'b0;
      #1;
      push("async_reset", 0, S_IDLE, 0); pop_check();
      @(negedge clk);
      reset = 1'b1;
      push("rise_after_reset", 0, S_ATT, 1);
      @(negedge clk); pop_check();

      // Short gate-low pulse in sustain: release then attack, no level change
      attack_step = '0; decay_step = '0;
      tick(); tick();
      push("sustain_again", 128, S_SUS, 1); pop_check();
      gate = 1'b0;
      push("pulse_release1", 128, S_REL, 1);
      @(negedge clk); pop_check();
      push("pulse_release2", 128, S_REL, 1);
      @(negedge clk); pop_check();
      gate = 1'b1;
      push("pulse_reattack", 128, S_ATT, 1);
      @(negedge clk); pop_check();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
